// File: rtl/brick_storage_arbiter_if.sv
// brick_storage_arbiter_if: collider, display and storage signals of the brick
// storage arbiter, bundled in one interface.
// master = arbiter side, slave = requester/storage side.
interface brick_storage_arbiter_if #(
   parameter int ADDR_W = 6
);
   // collider requester
   logic              col_req;
   logic [ADDR_W-1:0] col_address;
   logic              col_delete;
   logic              col_grant;
   logic              col_done;
   logic [18:0]       col_brick;

   // display requester (read-only)
   logic              disp_req;
   logic [ADDR_W-1:0] disp_address;
   logic              disp_grant;
   logic              disp_done;
   logic [18:0]       disp_brick;

   // brick storage
   logic [ADDR_W-1:0] st_address;
   logic              st_check_status;
   logic              st_delete_brick;
   logic              st_done;
   logic [18:0]       st_brick_out;
   logic              st_done_loading;

   modport master (
      input  col_req, col_address, col_delete,
      input  disp_req, disp_address,
      input  st_done, st_brick_out, st_done_loading,
      output col_grant, col_done, col_brick,
      output disp_grant, disp_done, disp_brick,
      output st_address, st_check_status, st_delete_brick
   );

   modport slave (
      output col_req, col_address, col_delete,
      output disp_req, disp_address,
      output st_done, st_brick_out, st_done_loading,
      input  col_grant, col_done, col_brick,
      input  disp_grant, disp_done, disp_brick,
      input  st_address, st_check_status, st_delete_brick
   );
endinterface

// File: rtl/brick_storage_arbiter.sv
// brick_storage_arbiter: round-robin arbiter between the collider and the
// display for single accesses to the brick storage.
// Flow: INIT (wait for storage load) -> IDLE -> ISSUE (one-cycle strobe)
//       -> WAIT (until st_done) -> RESP (done pulse, brick captured) -> IDLE.
// Optional feature: define BRICK_ARB_TIMEOUT_EN to add a WAIT watchdog that
// forces a response with brick 0 and a timeout_err pulse after TIMEOUT_CYCLES.
module brick_storage_arbiter #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int ADDR_W         = 6
) (
   input  logic                    clock,
   input  logic                    reset,
   brick_storage_arbiter_if.master bus,
   output logic                    busy,
   output logic                    timeout_err
);

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_IDLE  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic              owner_col_q, owner_col_d;   // 1: collider owns the access
   logic              last_col_q, last_col_d;     // 1: collider was granted last
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              del_q, del_d;
   logic [18:0]       col_brick_q, col_brick_d;
   logic [18:0]       disp_brick_q, disp_brick_d;
   logic              busy_q, busy_d;
   logic              tmo_q, tmo_d;               // current response is a watchdog expiry

   logic              wait_expired;
   logic              in_txn;
   logic [18:0]       resp_word;

   assign in_txn    = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_RESP);
   // Storage presents its brick register in RESP; a watchdog response returns 0.
   assign resp_word = tmo_q ? 19'd0 : bus.st_brick_out;

`ifdef BRICK_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   // Watchdog counter: counts cycles spent in WAIT, cleared in every other state
   always_comb begin
      wait_cnt_d = '0;
      if (state_q == S_WAIT) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
   end

   // Watchdog counter register
   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // The current WAIT cycle is the last one allowed
   assign wait_expired = (32'(wait_cnt_q) + 32'd1) >= 32'(TIMEOUT_CYCLES);
   assign timeout_err  = (state_q == S_RESP) && tmo_q;
`else
   // No watchdog: WAIT lasts until the storage answers.
   logic [31:0] unused_timeout_cycles;
   assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
   assign wait_expired = 1'b0;
   assign timeout_err  = 1'b0;
`endif

   // Next-state logic: arbitration, request latching and response capture
   always_comb begin
      state_d      = state_q;
      owner_col_d  = owner_col_q;
      last_col_d   = last_col_q;
      addr_d       = addr_q;
      del_d        = del_q;
      col_brick_d  = col_brick_q;
      disp_brick_d = disp_brick_q;
      tmo_d        = tmo_q;

      case (state_q)
         S_INIT: begin
            // Requests stay pending (they are levels) until storage is loaded.
            if (bus.st_done_loading) begin
               state_d = S_IDLE;
            end
         end

         S_IDLE: begin
            if (bus.col_req || bus.disp_req) begin
               // On contention the requester not granted last wins.
               owner_col_d = bus.col_req && (!bus.disp_req || !last_col_q);
               last_col_d  = owner_col_d;
               addr_d      = owner_col_d ? bus.col_address : bus.disp_address;
               del_d       = owner_col_d && bus.col_delete;
               tmo_d       = 1'b0;
               state_d     = S_ISSUE;
            end
         end

         S_ISSUE: begin
            state_d = S_WAIT;
         end

         S_WAIT: begin
            if (bus.st_done) begin
               state_d = S_RESP;
            end else if (wait_expired) begin
               tmo_d   = 1'b1;
               state_d = S_RESP;
            end
         end

         S_RESP: begin
            // Only the owner's brick register is updated; the other holds.
            if (owner_col_q) begin
               col_brick_d = resp_word;
            end else begin
               disp_brick_d = resp_word;
            end
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_INIT;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and datapath registers; reset aborts any transaction in flight
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_INIT;
         owner_col_q  <= 1'b0;
         last_col_q   <= 1'b0;
         addr_q       <= '0;
         del_q        <= 1'b0;
         col_brick_q  <= '0;
         disp_brick_q <= '0;
         busy_q       <= 1'b0;
         tmo_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_col_q  <= owner_col_d;
         last_col_q   <= last_col_d;
         addr_q       <= addr_d;
         del_q        <= del_d;
         col_brick_q  <= col_brick_d;
         disp_brick_q <= disp_brick_d;
         busy_q       <= busy_d;
         tmo_q        <= tmo_d;
      end
   end

   // Requester side: grant spans ISSUE..RESP, done and fresh brick in RESP
   assign bus.col_grant  = in_txn && owner_col_q;
   assign bus.disp_grant = in_txn && !owner_col_q;
   assign bus.col_done   = (state_q == S_RESP) && owner_col_q;
   assign bus.disp_done  = (state_q == S_RESP) && !owner_col_q;
   assign bus.col_brick  = bus.col_done  ? resp_word : col_brick_q;
   assign bus.disp_brick = bus.disp_done ? resp_word : disp_brick_q;

   // Storage side: address held from the latch, delete only while the access is open
   assign bus.st_address      = addr_q;
   assign bus.st_check_status = (state_q == S_ISSUE);
   assign bus.st_delete_brick = del_q && ((state_q == S_ISSUE) || (state_q == S_WAIT));

   // busy is registered from the next state so it is 0 right after reset
   assign busy = busy_q;

endmodule
